pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Drives stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding selects.
- Owns the data-memory handshake FSM, which freezes the pipeline while a multi-cycle load or store in MEM completes.
- Sits beside the datapath; it is the only source of stall_*/flush_* and mem_req.

Parameters:
TIMEOUT_CYCLES, 255, max WAIT cycles before mem_timeout asserts (1..2^CNT_W-1)
CNT_W, 8, width of the wait counter
LOAD_SRC, 2'b01, result_src encoding that identifies a load

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
rs1_d, rs2_d  in  5  source regs in ID
rs1_e, rs2_e, rd_e  in  5  source/dest regs in EX
rd_m, rd_w  in  5  dest reg in MEM/WB
reg_write_m, reg_write_w  in  1  write-back enables in MEM/WB
result_src_e  in  2  result select in EX (load detect)
pc_src_e  in  1  taken branch/jump resolved in EX
mem_access_m  in  1  load or store in MEM
mem_ack  in  1  data memory completion, valid in the same cycle as mem_req
mem_req  out  1  data memory request
stall_f, stall_d, stall_e, stall_m  out  1  hold PC / IF-ID / ID-EX / EX-MEM
flush_d, flush_e, flush_w  out  1  bubble IF-ID / ID-EX / MEM-WB
forward_a_e, forward_b_e  out  2  00 regfile, 01 WB result, 10 MEM alu result
mem_timeout  out  1  sticky error flag

Behaviour:
- While rst=0: state=IDLE, wait_cnt=0, mem_timeout=0. All outputs read 0 (forced, including the combinational outputs).
- FSM states are IDLE and WAIT.
  - IDLE: mem_req = mem_access_m. If mem_access_m && !mem_ack, go to WAIT; otherwise stay.
  - WAIT: mem_req=1. On mem_ack, go to IDLE and clear wait_cnt; otherwise increment wait_cnt, saturating.
- mem_stall = mem_req && !mem_ack.
  - A zero-wait ack in the request cycle causes no stall.
  - The access completes in the ack cycle; the next instruction reaches MEM on the following edge.
- mem_timeout is set when wait_cnt reaches TIMEOUT_CYCLES in WAIT. It clears only on reset. It does not alter sequencing.
- While mem_stall=1:
  - stall_f, stall_d, stall_e and stall_m are 1; flush_w=1.
  - flush_d=0 and flush_e=0, since EX is frozen and the branch is handled after the release.
  - The load-use and branch terms are masked.
- Otherwise:
  - lw_stall = (result_src_e==LOAD_SRC) && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
  - stall_f = stall_d = lw_stall && !pc_src_e.
  - flush_d = pc_src_e.
  - flush_e = lw_stall || pc_src_e.
  - stall_e = stall_m = flush_w = 0.
- Branch and load-use in the same cycle: branch wins. PC takes the target, and ID and EX are flushed.
- Forwarding (forward_a_e shown; forward_b_e is the same using rs2_e):
  - 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
  - else 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
  - else 00.
  - MEM has priority over WB.
- Forwarding is purely combinational and is unaffected by the FSM.
- Reset asserted in WAIT returns the FSM to IDLE immediately; mem_req drops asynchronously.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cycles (32, cycles with stall_d=1) and flush_cycles (32, cycles with flush_e=1).
  - Both counters are wrapping, reset to 0, and increment on clk.
- Macro undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - State encoding ST_IDLE, ST_WAIT.
  - Default LOAD_SRC.
- Sub-module mem_wait_fsm: IDLE/WAIT state, wait_cnt, mem_req, mem_stall, mem_timeout.
- Top level: hazard equations, forwarding, priority masking, optional counters.

Test Plan:
- Load x5 in EX (result_src_e=01, rd_e=5), rs1_d=5, pc_src_e=0 -> stall_f=stall_d=1, flush_e=1, flush_d=0 for exactly one cycle.
- rs1_e=7, rd_m=7/reg_write_m=1, rd_w=7/reg_write_w=1 -> forward_a_e=10; drop reg_write_m -> 01; rd_m=rd_w=0, rs1_e=0 -> 00.
- mem_access_m=1, mem_ack low for 3 cycles then high -> mem_req=1 for 4 cycles, stall_f/d/e/m=1 and flush_w=1 for 3 cycles, IDLE after; mem_ack high in first cycle -> no stall.
- Load-use and pc_src_e=1 together -> stall_f=0, flush_d=1, flush_e=1; pc_src_e=1 during mem_stall -> flush_d=flush_e=0 until ack.
- TIMEOUT_CYCLES=4, ack withheld 6 cycles -> mem_timeout rises after the 4th WAIT cycle and stays 1 after ack; rst=0 mid-WAIT -> mem_req=0 and all outputs 0 immediately, IDLE on release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the 5-stage pipeline hazard controller.
//   - Forwarding select encodings driven onto forward_a_e / forward_b_e
//   - Data-memory handshake FSM state encoding
//   - Default result_src value that marks a load in EX
//   - fwd_sel(): forwarding priority for one EX source operand
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] LOAD_SRC_DEFAULT = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // The MEM stage holds the younger result, so it is checked first.
  // Register x0 is never forwarded because it always reads as zero.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Data-memory handshake between the hazard controller and the data memory.
//   mem_access_m : load or store currently in MEM (from the datapath)
//   mem_req      : data memory request (from the controller)
//   mem_ack      : data memory completion, valid in the same cycle as mem_req
// Modports:
//   master : the hazard controller
//   slave  : the memory / datapath side
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;

  logic mem_access_m;
  logic mem_req;
  logic mem_ack;

  modport master (
    input  mem_access_m,
    input  mem_ack,
    output mem_req
  );

  modport slave (
    output mem_access_m,
    output mem_ack,
    input  mem_req
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// ---------------------------------------------------------------------------
// mem_wait_fsm
// Data-memory handshake FSM. Keeps mem_req up until the memory acknowledges
// and reports mem_stall for every cycle the access is still outstanding.
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles without ack before mem_timeout sets
//   CNT_W          : width of the wait counter
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   mem_access_m  : load/store present in MEM
//   mem_ack       : memory completion
//   mem_req       : memory request (forced low while rst=0)
//   mem_stall     : request outstanding and not acknowledged this cycle
//   mem_timeout   : sticky flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access_m,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_stall,
  output logic mem_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic             req_raw;

  // State, wait counter and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic. The timeout flag is set on the edge at which the
  // counter reaches the limit, so it is visible in the following cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    req_raw    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_raw    = mem_access_m;
        wait_cnt_d = '0;
        if (mem_access_m && !mem_ack) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (mem_ack) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (wait_cnt_d >= TIMEOUT_VAL) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // While reset is held the state is IDLE, but IDLE would still echo
  // mem_access_m, so the request is gated by reset as well.
  assign mem_req     = rst & req_raw;
  assign mem_stall   = mem_req & ~mem_ack;
  assign mem_timeout = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 5-stage RISC-V pipeline.
// Produces the stall/flush enables for the pipeline registers, the EX-stage
// forwarding selects, and (through mem_wait_fsm) the data-memory request.
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles before mem_timeout sets (1..2^CNT_W-1)
//   CNT_W          : wait counter width
//   LOAD_SRC       : result_src_e encoding that marks a load
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   rs1_d, rs2_d                : ID source registers
//   rs1_e, rs2_e, rd_e          : EX source/destination registers
//   rd_m, rd_w                  : MEM/WB destination registers
//   reg_write_m, reg_write_w    : MEM/WB write-back enables
//   result_src_e                : EX result select (load detect)
//   pc_src_e                    : taken branch/jump resolved in EX
//   mem_bus                     : data-memory handshake (master modport)
//   stall_f/d/e/m               : hold PC, IF/ID, ID/EX, EX/MEM
//   flush_d/e/w                 : bubble IF/ID, ID/EX, MEM/WB
//   forward_a_e, forward_b_e    : 00 regfile, 01 WB result, 10 MEM result
//   mem_timeout                 : sticky memory timeout flag
// Optional build macro HAZARD_PERF_CNT_EN adds:
//   stall_cycles : wrapping count of cycles with stall_d=1
//   flush_cycles : wrapping count of cycles with flush_e=1
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         CNT_W          = 8,
  parameter logic [1:0] LOAD_SRC       = LOAD_SRC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                rs1_d,
  input  logic [4:0]                rs2_d,
  input  logic [4:0]                rs1_e,
  input  logic [4:0]                rs2_e,
  input  logic [4:0]                rd_e,
  input  logic [4:0]                rd_m,
  input  logic [4:0]                rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  input  logic [1:0]                result_src_e,
  input  logic                      pc_src_e,
  pipe_hazard_ctrl_if.master        mem_bus,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      stall_m,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      flush_w,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_cycles
`endif
);

  logic mem_stall;
  logic lw_stall;

  mem_wait_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mem_wait_fsm (
    .clk          (clk),
    .rst          (rst),
    .mem_access_m (mem_bus.mem_access_m),
    .mem_ack      (mem_bus.mem_ack),
    .mem_req      (mem_bus.mem_req),
    .mem_stall    (mem_stall),
    .mem_timeout  (mem_timeout)
  );

  // A load in EX whose destination is read by the instruction in ID.
  assign lw_stall = (result_src_e == LOAD_SRC) && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Stall/flush priority: an outstanding memory access freezes the whole
  // pipeline and hides the load-use and branch terms (EX is frozen, so the
  // branch is acted on once the access is released). Otherwise a taken
  // branch beats a load-use stall: PC takes the target and both ID and EX
  // are flushed. Every output is forced low while reset is held.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (rst) begin
      forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
      forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall && !pc_src_e;
        stall_d = lw_stall && !pc_src_e;
        flush_d = pc_src_e;
        flush_e = lw_stall || pc_src_e;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrapping event counters for stall and flush cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall_d) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_e) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
